// File: rtl/mii_rx_byte_assembler.sv
// MII receive byte assembler: strips preamble/SFD, packs nibbles (low first) into bytes
// and emits each frame as a byte-wide AXI-Stream with one-byte hold so tlast is exact.
module mii_rx_byte_assembler #(
  parameter int MIN_PREAMBLE = 2,
  parameter int MAX_LEN      = 1518
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] mii_rxd,
  input  logic       mii_rx_dv,
  input  logic       mii_rx_er,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       stat_rx_frame_good,
  output logic       stat_rx_frame_bad,
  output logic       stat_rx_oversize
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_DROP     = 2'd3
  } state_t;

  localparam logic [3:0]  MIN_PRE_C = 4'(MIN_PREAMBLE);
  localparam logic [13:0] MAX_LEN_C = 14'(MAX_LEN);

  state_t      state_r, state_s;
  logic        armed_r, armed_s;
  logic [3:0]  pre_cnt_r, pre_cnt_s;
  logic        phase_r, phase_s;
  logic [3:0]  low_r, low_s;
  logic [7:0]  held_r, held_s;
  logic        held_valid_r, held_valid_s;
  logic        err_r, err_s;
  logic [13:0] byte_cnt_r, byte_cnt_s;
  logic [7:0]  tdata_s;
  logic        tvalid_s, tlast_s, tuser_s;
  logic        good_s, bad_s, over_s;
  logic [7:0]  byte_s;
  logic        end_bad_s;

  assign byte_s    = {mii_rxd, low_r};
  assign end_bad_s = err_r | phase_r;

  // Next-state, datapath and output decode
  always_comb begin
    state_s      = state_r;
    armed_s      = armed_r;
    pre_cnt_s    = pre_cnt_r;
    phase_s      = phase_r;
    low_s        = low_r;
    held_s       = held_r;
    held_valid_s = held_valid_r;
    err_s        = err_r;
    byte_cnt_s   = byte_cnt_r;
    tdata_s      = m_axis_tdata;
    tvalid_s     = 1'b0;
    tlast_s      = m_axis_tlast;
    tuser_s      = m_axis_tuser;
    good_s       = 1'b0;
    bad_s        = 1'b0;
    over_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!mii_rx_dv) begin
          armed_s = 1'b1;
        end else if (armed_r && (mii_rxd == 4'h5)) begin
          state_s   = ST_PREAMBLE;
          pre_cnt_s = 4'd1;
        end else begin
          state_s = ST_DROP;
        end
      end
      ST_PREAMBLE: begin
        if (!mii_rx_dv) begin
          state_s = ST_IDLE;
        end else if (mii_rxd == 4'h5) begin
          if (pre_cnt_r != 4'd15) begin
            pre_cnt_s = pre_cnt_r + 4'd1;
          end else begin
            pre_cnt_s = pre_cnt_r;
          end
        end else if ((mii_rxd == 4'hD) && (pre_cnt_r >= MIN_PRE_C)) begin
          state_s      = ST_PAYLOAD;
          phase_s      = 1'b0;
          byte_cnt_s   = 14'd0;
          held_valid_s = 1'b0;
          err_s        = 1'b0;
        end else begin
          state_s = ST_DROP;
        end
      end
      ST_PAYLOAD: begin
        if (!mii_rx_dv) begin
          state_s = ST_IDLE;
          if (held_valid_r) begin
            tvalid_s = 1'b1;
            tdata_s  = held_r;
            tlast_s  = 1'b1;
            tuser_s  = end_bad_s;
            good_s   = ~end_bad_s;
            bad_s    = end_bad_s;
          end else begin
            bad_s = 1'b1;
          end
        end else begin
          if (mii_rx_er) begin
            err_s = 1'b1;
          end else begin
            err_s = err_r;
          end
          if (!phase_r) begin
            low_s   = mii_rxd;
            phase_s = 1'b1;
          end else if (byte_cnt_r == MAX_LEN_C) begin
            // Byte MAX_LEN+1 just completed: close the frame on the held byte.
            phase_s  = 1'b0;
            state_s  = ST_DROP;
            tvalid_s = 1'b1;
            tdata_s  = held_r;
            tlast_s  = 1'b1;
            tuser_s  = 1'b1;
            bad_s    = 1'b1;
            over_s   = 1'b1;
          end else begin
            phase_s      = 1'b0;
            byte_cnt_s   = byte_cnt_r + 14'd1;
            held_s       = byte_s;
            held_valid_s = 1'b1;
            if (held_valid_r) begin
              tvalid_s = 1'b1;
              tdata_s  = held_r;
              tlast_s  = 1'b0;
              tuser_s  = 1'b0;
            end else begin
              tvalid_s = 1'b0;
            end
          end
        end
      end
      ST_DROP: begin
        if (!mii_rx_dv) begin
          state_s = ST_IDLE;
          armed_s = 1'b1;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r            <= ST_IDLE;
      armed_r            <= 1'b0;
      pre_cnt_r          <= 4'd0;
      phase_r            <= 1'b0;
      low_r              <= 4'd0;
      held_r             <= 8'd0;
      held_valid_r       <= 1'b0;
      err_r              <= 1'b0;
      byte_cnt_r         <= 14'd0;
      m_axis_tdata       <= 8'd0;
      m_axis_tvalid      <= 1'b0;
      m_axis_tlast       <= 1'b0;
      m_axis_tuser       <= 1'b0;
      stat_rx_frame_good <= 1'b0;
      stat_rx_frame_bad  <= 1'b0;
      stat_rx_oversize   <= 1'b0;
    end else begin
      state_r            <= state_s;
      armed_r            <= armed_s;
      pre_cnt_r          <= pre_cnt_s;
      phase_r            <= phase_s;
      low_r              <= low_s;
      held_r             <= held_s;
      held_valid_r       <= held_valid_s;
      err_r              <= err_s;
      byte_cnt_r         <= byte_cnt_s;
      m_axis_tdata       <= tdata_s;
      m_axis_tvalid      <= tvalid_s;
      m_axis_tlast       <= tlast_s;
      m_axis_tuser       <= tuser_s;
      stat_rx_frame_good <= good_s;
      stat_rx_frame_bad  <= bad_s;
      stat_rx_oversize   <= over_s;
    end
  end

endmodule

// File: tb/tb_mii_rx_byte_assembler.sv
// Bench for mii_rx_byte_assembler: two instances (MIN_PREAMBLE 2 / MAX_LEN 1518 and
// MIN_PREAMBLE 4 / MAX_LEN 4) share one MII stream; a frame-level model predicts beats.
module tb_mii_rx_byte_assembler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] mii_rxd = 4'h0;
  logic       mii_rx_dv = 1'b0;
  logic       mii_rx_er = 1'b0;

  logic [7:0] a_tdata, b_tdata;
  logic       a_tvalid, a_tlast, a_tuser, a_good, a_bad, a_over;
  logic       b_tvalid, b_tlast, b_tuser, b_good, b_bad, b_over;

  mii_rx_byte_assembler #(.MIN_PREAMBLE(2), .MAX_LEN(1518)) u_a (
    .clk(clk), .rst(rst), .mii_rxd(mii_rxd), .mii_rx_dv(mii_rx_dv), .mii_rx_er(mii_rx_er),
    .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tlast(a_tlast),
    .m_axis_tuser(a_tuser), .stat_rx_frame_good(a_good), .stat_rx_frame_bad(a_bad),
    .stat_rx_oversize(a_over));

  mii_rx_byte_assembler #(.MIN_PREAMBLE(4), .MAX_LEN(4)) u_b (
    .clk(clk), .rst(rst), .mii_rxd(mii_rxd), .mii_rx_dv(mii_rx_dv), .mii_rx_er(mii_rx_er),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tlast(b_tlast),
    .m_axis_tuser(b_tuser), .stat_rx_frame_good(b_good), .stat_rx_frame_bad(b_bad),
    .stat_rx_oversize(b_over));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic [7:0] d; logic l; logic u; int c; } beat_t;
  typedef struct { int id; logic g; logic b; logic o; int c; } stat_t;

  beat_t      act_b[$], exp_b[$];
  stat_t      act_s[$], exp_s[$];
  logic [3:0] pay_q[$];
  bit         er_q[$];
  int         nib_cyc[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         viol = 0;
  logic       pa_v = 1'b0, pb_v = 1'b0;

  // Record every beat and status pulse with the cycle it appeared in.
  always @(negedge clk) begin
    if (a_tvalid) act_b.push_back('{0, a_tdata, a_tlast, a_tuser, cyc});
    if (b_tvalid) act_b.push_back('{1, b_tdata, b_tlast, b_tuser, cyc});
    if (a_good || a_bad || a_over) act_s.push_back('{0, a_good, a_bad, a_over, cyc});
    if (b_good || b_bad || b_over) act_s.push_back('{1, b_good, b_bad, b_over, cyc});
    if ((a_tvalid && pa_v && !a_tlast) || (b_tvalid && pb_v && !b_tlast)) viol <= viol + 1;
    pa_v <= a_tvalid;
    pb_v <= b_tvalid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic dv, input logic [3:0] d, input logic er);
    @(posedge clk);
    #1;
    mii_rx_dv = dv;
    mii_rxd   = d;
    mii_rx_er = er;
  endtask

  task automatic load(input int n, input logic [63:0] nibs, input logic [15:0] ers);
    pay_q.delete();
    er_q.delete();
    for (int i = 0; i < n; i++) begin
      pay_q.push_back(nibs[4*i +: 4]);
      er_q.push_back(ers[i]);
    end
  endtask

  // Frame-level reference: what a receiver with these limits must deliver for one frame.
  task automatic model(input int id, input int npre, input logic [3:0] sfd, input int fall);
    int mn, mx, nb;
    logic odd, err, u;
    mn = (id == 0) ? 2 : 4;
    mx = (id == 0) ? 1518 : 4;
    if (npre < mn || sfd != 4'hD) return;
    nb  = pay_q.size() / 2;
    odd = (pay_q.size() % 2) == 1;
    err = 1'b0;
    foreach (er_q[i]) err |= er_q[i];
    if (nb > mx) begin
      for (int k = 0; k < mx; k++)
        exp_b.push_back('{id, {pay_q[2*k+1], pay_q[2*k]}, k == mx - 1, k == mx - 1,
                          nib_cyc[2*k+3] + 1});
      exp_s.push_back('{id, 1'b0, 1'b1, 1'b1, nib_cyc[2*mx+1] + 1});
    end else if (nb == 0) begin
      exp_s.push_back('{id, 1'b0, 1'b1, 1'b0, fall + 1});
    end else begin
      u = err | odd;
      for (int k = 0; k < nb; k++)
        exp_b.push_back('{id, {pay_q[2*k+1], pay_q[2*k]}, k == nb - 1, (k == nb - 1) && u,
                          (k == nb - 1) ? fall + 1 : nib_cyc[2*k+3] + 1});
      exp_s.push_back('{id, ~u, u, 1'b0, fall + 1});
    end
  endtask

  task automatic compare_frame(input string tag);
    beat_t ab[$], eb[$];
    stat_t as_[$], es[$];
    for (int id = 0; id < 2; id++) begin
      ab.delete(); eb.delete(); as_.delete(); es.delete();
      foreach (act_b[i]) if (act_b[i].id == id) ab.push_back(act_b[i]);
      foreach (exp_b[i]) if (exp_b[i].id == id) eb.push_back(exp_b[i]);
      foreach (act_s[i]) if (act_s[i].id == id) as_.push_back(act_s[i]);
      foreach (exp_s[i]) if (exp_s[i].id == id) es.push_back(exp_s[i]);
      check($sformatf("%s_u%0d_nbeats", tag, id), ab.size(), eb.size());
      for (int i = 0; i < ab.size() && i < eb.size(); i++) begin
        check($sformatf("%s_u%0d_beat%0d_dlu", tag, id, i),
              {ab[i].d, ab[i].l, ab[i].u}, {eb[i].d, eb[i].l, eb[i].u});
        check($sformatf("%s_u%0d_beat%0d_cyc", tag, id, i), ab[i].c, eb[i].c);
      end
      check($sformatf("%s_u%0d_nstat", tag, id), as_.size(), es.size());
      for (int i = 0; i < as_.size() && i < es.size(); i++) begin
        check($sformatf("%s_u%0d_stat_gbo", tag, id),
              {as_[i].g, as_[i].b, as_[i].o}, {es[i].g, es[i].b, es[i].o});
        check($sformatf("%s_u%0d_stat_cyc", tag, id), as_[i].c, es[i].c);
      end
    end
    act_b.delete(); exp_b.delete(); act_s.delete(); exp_s.delete();
  endtask

  task automatic run_frame(input string tag, input int npre, input logic [3:0] sfd);
    int fall;
    act_b.delete(); act_s.delete(); exp_b.delete(); exp_s.delete(); nib_cyc.delete();
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    repeat (npre) step(1'b1, 4'h5, 1'b0);
    step(1'b1, sfd, 1'b0);
    foreach (pay_q[i]) begin
      step(1'b1, pay_q[i], er_q[i]);
      nib_cyc.push_back(cyc);
    end
    step(1'b0, 4'h0, 1'b0);
    fall = cyc;
    repeat (4) step(1'b0, 4'h0, 1'b0);
    model(0, npre, sfd, fall);
    model(1, npre, sfd, fall);
    compare_frame(tag);
  endtask

  initial begin
    int n3;
    logic [3:0] sfd;
    // Reset with dv low; every output must be zero.
    repeat (3) step(1'b0, 4'h0, 1'b0);
    @(negedge clk);
    check("reset_outputs_a", {a_tdata, a_tvalid, a_tlast, a_tuser, a_good, a_bad, a_over}, 32'd0);
    check("reset_outputs_b", {b_tdata, b_tvalid, b_tlast, b_tuser, b_good, b_bad, b_over}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    load(6, 64'h030201, 16'h0000);      run_frame("basic", 15, 4'hD);
    load(6, 64'h030201, 16'h0004);      run_frame("rx_er", 15, 4'hD);
    load(5, 64'h70201, 16'h0000);       run_frame("odd_nibble", 15, 4'hD);
    load(2, 64'h01, 16'h0000);          run_frame("short_pre", 3, 4'hD);
    load(6, 64'h030201, 16'h0000);      run_frame("after_short", 4, 4'hD);
    load(0, 64'h0, 16'h0000);           run_frame("zero_nibbles", 5, 4'hD);
    load(1, 64'h9, 16'h0000);           run_frame("one_nibble", 5, 4'hD);
    load(12, 64'h151413121110, 16'h0);  run_frame("oversize", 8, 4'hD);
    load(8, 64'h44332211, 16'h0000);    run_frame("exact_max", 4, 4'hD);
    load(4, 64'h2211, 16'h0000);        run_frame("bad_sfd", 6, 4'h7);

    // Reset one cycle after the second payload byte while dv stays high.
    act_b.delete(); act_s.delete(); exp_b.delete(); exp_s.delete();
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    repeat (7) step(1'b1, 4'h5, 1'b0);
    step(1'b1, 4'hD, 1'b0);
    step(1'b1, 4'h5, 1'b0);
    step(1'b1, 4'hA, 1'b0);
    step(1'b1, 4'hC, 1'b0);
    step(1'b1, 4'h3, 1'b0);
    n3 = cyc;
    step(1'b1, 4'h5, 1'b0);
    rst = 1'b1;
    step(1'b1, 4'h5, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("midreset_out_a", {a_tdata, a_tvalid, a_tlast, a_tuser, a_good, a_bad, a_over}, 32'd0);
    check("midreset_out_b", {b_tdata, b_tvalid, b_tlast, b_tuser, b_good, b_bad, b_over}, 32'd0);
    step(1'b1, 4'h5, 1'b0);
    step(1'b1, 4'h5, 1'b0);
    step(1'b1, 4'hD, 1'b0);
    step(1'b1, 4'h1, 1'b0);
    step(1'b1, 4'h0, 1'b0);
    repeat (5) step(1'b0, 4'h0, 1'b0);
    exp_b.push_back('{0, 8'hA5, 1'b0, 1'b0, n3 + 1});
    exp_b.push_back('{1, 8'hA5, 1'b0, 1'b0, n3 + 1});
    compare_frame("midreset");
    load(6, 64'h030201, 16'h0000);      run_frame("after_reset", 15, 4'hD);

    for (int f = 0; f < 25; f++) begin
      sfd = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'hD;
      if (sfd == 4'h5) sfd = 4'h0;
      load($urandom_range(0, 14), {$urandom, $urandom}, 16'($urandom & $urandom & $urandom));
      run_frame($sformatf("rand%0d", f), $urandom_range(1, 20), sfd);
    end

    check("no_back_to_back_beats", viol, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
